// File: rtl/count_checker_pkg.sv
// Shared types and constants for the counter built-in self-test checker.
// Holds the FSM state encoding and the saturating error-counter helpers.
package count_checker_pkg;

    localparam int CC_ERR_W   = 8;
    localparam int CC_ERR_MAX = 255;

    typedef enum logic [2:0] {
        CC_IDLE = 3'd0,
        CC_LOAD = 3'd1,
        CC_CAPT = 3'd2,
        CC_RUN  = 3'd3,
        CC_DONE = 3'd4
    } cc_state_e;

    // Increment that sticks at the maximum instead of wrapping back to zero.
    function automatic logic [CC_ERR_W-1:0] cc_sat_inc(input logic [CC_ERR_W-1:0] value);
        if (value == CC_ERR_W'(CC_ERR_MAX)) begin
            return value;
        end
        return value + CC_ERR_W'(1);
    endfunction

endpackage

// File: rtl/cc_err_tracker.sv
// Saturating mismatch counter with capture of the first mismatch of a run.
// A clear starts a new run; the captured values then hold until the next clear.
module cc_err_tracker
    import count_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear,
    input  logic                check,
    input  logic                fail,
    input  logic [WIDTH-1:0]    exp_val,
    input  logic [WIDTH-1:0]    got_val,
    output logic [CC_ERR_W-1:0] err_count,
    output logic [WIDTH-1:0]    first_exp,
    output logic [WIDTH-1:0]    first_got,
    output logic                err_any
);

    assign err_any = (err_count != '0);

    // The first mismatch is recognised by the count still being zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            err_count <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else if (check && fail) begin
            err_count <= cc_sat_inc(err_count);
            if (err_count == '0) begin
                first_exp <= exp_val;
                first_got <= got_val;
            end
        end
    end

endmodule

// File: rtl/count_checker.sv
// Built-in self-test driver for a loadable up-counter: loads a start value,
// then checks the load and every following increment against the expected sequence.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [WIDTH-1:0]    cmd_start_i,
    input  logic [RUN_W-1:0]    cmd_run_i,
    output logic                load_o,
    output logic [WIDTH-1:0]    load_value_o,
    input  logic [WIDTH-1:0]    count_value_i,
    input  logic                count_valid_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [CC_ERR_W-1:0] err_count_o,
    output logic [WIDTH-1:0]    first_err_exp_o,
    output logic [WIDTH-1:0]    first_err_got_o
);

    localparam logic [2:0] ST_IDLE = CC_IDLE;
    localparam logic [2:0] ST_LOAD = CC_LOAD;
    localparam logic [2:0] ST_CAPT = CC_CAPT;
    localparam logic [2:0] ST_RUN  = CC_RUN;
    localparam logic [2:0] ST_DONE = CC_DONE;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] exp_q;
    logic [RUN_W-1:0] remain_q;

    logic             accept;
    logic             check;
    logic             fail;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_exp;
    logic             err_any;

    assign accept    = cmd_valid_i && (state == ST_IDLE);
    assign check     = (state == ST_CAPT) || (state == ST_RUN);
    assign chk_exp   = (state == ST_CAPT) ? start_q : exp_q;
    assign chk_valid = (state == ST_RUN);
    assign fail      = check && ((count_value_i != chk_exp) || (count_valid_i != chk_valid));

    // CAPT leaves straight for DONE when no increment checks were requested.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_CAPT;
            ST_CAPT: state_next = (remain_q != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (remain_q == RUN_W'(1)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            load_o       <= 1'b0;
            load_value_o <= '0;
            cmd_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            start_q      <= '0;
            exp_q        <= '0;
            remain_q     <= '0;
        end else begin
            state       <= state_next;
            load_o      <= (state_next == ST_LOAD);
            cmd_ready_o <= (state_next == ST_IDLE);
            busy_o      <= (state_next != ST_IDLE);
            done_o      <= (state_next == ST_DONE);

            if (accept) begin
                start_q      <= cmd_start_i;
                load_value_o <= cmd_start_i;
                remain_q     <= cmd_run_i;
                pass_o       <= 1'b0;
            end

            if (state == ST_CAPT) begin
                exp_q <= start_q + WIDTH'(1);
            end

            if (state == ST_RUN) begin
                exp_q    <= exp_q + WIDTH'(1);
                remain_q <= remain_q - RUN_W'(1);
            end

            // The final check lands on the same edge, so fold its result in here.
            if (check && (state_next == ST_DONE)) begin
                pass_o <= !(err_any || fail);
            end
        end
    end

    cc_err_tracker #(
        .WIDTH (WIDTH)
    ) u_err_tracker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (accept),
        .check     (check),
        .fail      (fail),
        .exp_val   (chk_exp),
        .got_val   (count_value_i),
        .err_count (err_count_o),
        .first_exp (first_err_exp_o),
        .first_got (first_err_got_o),
        .err_any   (err_any)
    );

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: plays the counter side from per-run
// observation tables and compares against a sequence-level reference model.
module tb_count_checker;

    localparam int WIDTH = 4;
    localparam int RUN_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [WIDTH-1:0] cmd_start_i;
    logic [RUN_W-1:0] cmd_run_i;
    logic             load_o;
    logic [WIDTH-1:0] load_value_o;
    logic [WIDTH-1:0] count_value_i;
    logic             count_valid_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [7:0]       err_count_o;
    logic [WIDTH-1:0] first_err_exp_o;
    logic [WIDTH-1:0] first_err_got_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    count_checker #(
        .WIDTH (WIDTH),
        .RUN_W (RUN_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_start_i     (cmd_start_i),
        .cmd_run_i       (cmd_run_i),
        .load_o          (load_o),
        .load_value_o    (load_value_o),
        .count_value_i   (count_value_i),
        .count_valid_i   (count_valid_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .err_count_o     (err_count_o),
        .first_err_exp_o (first_err_exp_o),
        .first_err_got_o (first_err_got_o)
    );

    task automatic test_reset();
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_start_i   = '0;
        cmd_run_i     = '0;
        count_value_i = '0;
        count_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (load_o !== 1'b0)        begin failures++; $display("[TB] FAIL rst_load_o got=%0h exp=0", load_o); end
        checks++; if (load_value_o !== 4'h0)  begin failures++; $display("[TB] FAIL rst_load_value got=%0h exp=0", load_value_o); end
        checks++; if (cmd_ready_o !== 1'b1)   begin failures++; $display("[TB] FAIL rst_cmd_ready got=%0h exp=1", cmd_ready_o); end
        checks++; if (busy_o !== 1'b0)        begin failures++; $display("[TB] FAIL rst_busy got=%0h exp=0", busy_o); end
        checks++; if (done_o !== 1'b0)        begin failures++; $display("[TB] FAIL rst_done got=%0h exp=0", done_o); end
        checks++; if (pass_o !== 1'b0)        begin failures++; $display("[TB] FAIL rst_pass got=%0h exp=0", pass_o); end
        checks++; if (err_count_o !== 8'd0)   begin failures++; $display("[TB] FAIL rst_err_count got=%0d exp=0", err_count_o); end
        checks++; if (first_err_exp_o !== 4'h0) begin failures++; $display("[TB] FAIL rst_first_exp got=%0h exp=0", first_err_exp_o); end
        checks++; if (first_err_got_o !== 4'h0) begin failures++; $display("[TB] FAIL rst_first_got got=%0h exp=0", first_err_got_o); end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // mode: 0 good counter, 1 random faults, 2 every valid bit inverted, 3 value 6 on 2nd RUN cycle
    task automatic test_run(input string tag, input logic [WIDTH-1:0] s, input int n, input int mode);
        logic [WIDTH-1:0] ov [0:255];
        bit               vl [0:255];
        logic [WIDTH-1:0] ev;
        bit               evld;
        int               e_err;
        logic [WIDTH-1:0] e_fexp;
        logic [WIDTH-1:0] e_fgot;

        e_err  = 0;
        e_fexp = '0;
        e_fgot = '0;
        for (int i = 0; i <= n; i++) begin
            ev    = WIDTH'((int'(s) + i) % 16);
            evld  = (i != 0);
            ov[i] = ev;
            vl[i] = evld;
            case (mode)
                1: if ($urandom_range(0, 4) == 0) begin
                       if ($urandom_range(0, 1) == 1) ov[i] = ov[i] ^ WIDTH'($urandom_range(1, 15));
                       else                           vl[i] = !vl[i];
                   end
                2: vl[i] = !vl[i];
                3: if (i == 2) ov[i] = 4'h6;
                default: ;
            endcase
            if (ov[i] != ev || vl[i] != evld) begin
                if (e_err == 0) begin
                    e_fexp = ev;
                    e_fgot = ov[i];
                end
                if (e_err < 255) e_err++;
            end
        end

        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL %s ready_before got=%0h exp=1", tag, cmd_ready_o); end
        cmd_valid_i = 1'b1;
        cmd_start_i = s;
        cmd_run_i   = RUN_W'(n);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_start_i = ~s;
        checks++; if (load_o !== 1'b1)       begin failures++; $display("[TB] FAIL %s load_high got=%0h exp=1", tag, load_o); end
        checks++; if (load_value_o !== s)    begin failures++; $display("[TB] FAIL %s load_value got=%0h exp=%0h", tag, load_value_o, s); end
        checks++; if (busy_o !== 1'b1)       begin failures++; $display("[TB] FAIL %s busy got=%0h exp=1", tag, busy_o); end
        checks++; if (cmd_ready_o !== 1'b0)  begin failures++; $display("[TB] FAIL %s ready_busy got=%0h exp=0", tag, cmd_ready_o); end
        checks++; if (pass_o !== 1'b0)       begin failures++; $display("[TB] FAIL %s pass_cleared got=%0h exp=0", tag, pass_o); end
        checks++; if (err_count_o !== 8'd0)  begin failures++; $display("[TB] FAIL %s err_cleared got=%0d exp=0", tag, err_count_o); end
        checks++; if (first_err_exp_o !== 4'h0) begin failures++; $display("[TB] FAIL %s fexp_cleared got=%0h exp=0", tag, first_err_exp_o); end

        @(posedge clk_i);
        #1;
        count_value_i = ov[0];
        count_valid_i = vl[0];
        checks++; if (load_o !== 1'b0) begin failures++; $display("[TB] FAIL %s load_drop got=%0h exp=0", tag, load_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL %s done_capt got=%0h exp=0", tag, done_o); end

        for (int i = 1; i <= n; i++) begin
            @(posedge clk_i);
            #1;
            count_value_i = ov[i];
            count_valid_i = vl[i];
            checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL %s done_early cyc=%0d got=%0h exp=0", tag, i, done_o); end
        end

        @(posedge clk_i);
        #1;
        count_value_i = '0;
        count_valid_i = 1'b0;
        checks++; if (done_o !== 1'b1)            begin failures++; $display("[TB] FAIL %s done_pulse got=%0h exp=1", tag, done_o); end
        checks++; if (pass_o !== (e_err == 0))    begin failures++; $display("[TB] FAIL %s pass got=%0h exp=%0h", tag, pass_o, (e_err == 0)); end
        checks++; if (err_count_o !== 8'(e_err))  begin failures++; $display("[TB] FAIL %s err_count got=%0d exp=%0d", tag, err_count_o, e_err); end
        checks++; if (first_err_exp_o !== e_fexp) begin failures++; $display("[TB] FAIL %s first_exp got=%0h exp=%0h", tag, first_err_exp_o, e_fexp); end
        checks++; if (first_err_got_o !== e_fgot) begin failures++; $display("[TB] FAIL %s first_got got=%0h exp=%0h", tag, first_err_got_o, e_fgot); end

        @(posedge clk_i);
        #1;
        checks++; if (done_o !== 1'b0)            begin failures++; $display("[TB] FAIL %s done_one_cycle got=%0h exp=0", tag, done_o); end
        checks++; if (cmd_ready_o !== 1'b1)       begin failures++; $display("[TB] FAIL %s ready_after got=%0h exp=1", tag, cmd_ready_o); end
        checks++; if (busy_o !== 1'b0)            begin failures++; $display("[TB] FAIL %s busy_after got=%0h exp=0", tag, busy_o); end
        checks++; if (pass_o !== (e_err == 0))    begin failures++; $display("[TB] FAIL %s pass_hold got=%0h exp=%0h", tag, pass_o, (e_err == 0)); end
        checks++; if (err_count_o !== 8'(e_err))  begin failures++; $display("[TB] FAIL %s err_hold got=%0d exp=%0d", tag, err_count_o, e_err); end
    endtask

    task automatic test_basic();
        test_run("basic_s3_n5", 4'h3, 5, 0);
    endtask

    task automatic test_wrap();
        test_run("wrap_sE_n4", 4'hE, 4, 0);
        test_run("wrap_sF_n3", 4'hF, 3, 0);
    endtask

    task automatic test_load_only();
        test_run("load_only_s9", 4'h9, 0, 0);
    endtask

    task automatic test_fault_inject();
        test_run("fault_s3", 4'h3, 5, 3);
    endtask

    task automatic test_saturation();
        test_run("saturate_n255", 4'h2, 255, 2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            test_run($sformatf("random_%0d", r), WIDTH'($urandom_range(0, 15)),
                     int'($urandom_range(0, 12)), (r % 2 == 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] s;
        s = 4'h3;
        cmd_valid_i = 1'b1;
        cmd_start_i = s;
        cmd_run_i   = 8'd10;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        count_value_i = s;
        count_valid_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk_i);
            #1;
            count_value_i = s + WIDTH'(i);
            count_valid_i = 1'b1;
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        count_value_i = '0;
        count_valid_i = 1'b0;
        checks++; if (load_o !== 1'b0)      begin failures++; $display("[TB] FAIL midrst_load got=%0h exp=0", load_o); end
        checks++; if (busy_o !== 1'b0)      begin failures++; $display("[TB] FAIL midrst_busy got=%0h exp=0", busy_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%0h exp=1", cmd_ready_o); end
        checks++; if (err_count_o !== 8'd0) begin failures++; $display("[TB] FAIL midrst_err got=%0d exp=0", err_count_o); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done cyc=%0d got=%0h exp=0", i, done_o); end
            @(posedge clk_i);
            #1;
        end
        test_run("after_reset_s7", 4'h7, 3, 0);
    endtask

    task automatic test_back_to_back();
        test_run("b2b_a", 4'hC, 2, 0);
        test_run("b2b_b", 4'h0, 1, 1);
        test_run("b2b_c", 4'h5, 6, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_load_only();
        test_fault_inject();
        test_saturation();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
